// File: rtl/stream_cipher_core_if.sv
// Streaming data interface of the stream cipher core: an input word channel
// and an output word channel, each with a valid/ready handshake.
// The master side produces input words and consumes output words; the core is the slave.
interface stream_cipher_core_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_cipher_core.sv
// Keyed Galois-LFSR stream cipher. Each accepted word is XORed with the low
// DATA_W bits of the LFSR state. The LFSR then advances DATA_W steps within
// the same cycle. Encryption and decryption are the same operation.
// The core applies backpressure through in_ready and uses a registered output stage.
module stream_cipher_core #(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter int                WARMUP = 0,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              key_load,
  input  logic [LFSR_W-1:0] key_in,
  stream_cipher_core_if.slave bus,
  output logic              keyed,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [1:0] ST_UNKEYED = 2'd0;
  localparam logic [1:0] ST_WARM    = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam logic [7:0] WARM_WORDS = 8'(WARMUP);

  logic [1:0]        fsm;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [7:0]        warm_cnt;
  logic              accept;

  // One word advance: DATA_W Galois steps (shift right, fold TAPS in when the lsb was 1).
  function automatic logic [LFSR_W-1:0] word_advance(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] v;
    logic              lsb;
    v = s;
    for (int i = 0; i < DATA_W; i++) begin
      lsb = v[0];
      v   = v >> 1;
      if (lsb) begin
        v = v ^ TAPS;
      end
    end
    return v;
  endfunction

  // The key load always wins over the input channel, and a full, stalled output stage blocks new words.
  assign bus.in_ready = ena & (fsm == ST_RUN) & ~key_load & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  // Next LFSR state for a word accept or a warm-up cycle.
  always_comb begin
    lfsr_next = word_advance(lfsr);
  end

  // Main sequential logic: key load, warm-up, data path, word counter and output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm          <= ST_UNKEYED;
      lfsr         <= '0;
      warm_cnt     <= 8'd0;
      keyed        <= 1'b0;
      word_count   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (ena) begin
      if (key_load) begin
        // An all-zero seed would lock the LFSR at zero, so substitute 1.
        if (key_in == '0) begin
          lfsr <= LFSR_W'(1);
        end else begin
          lfsr <= key_in;
        end
        word_count    <= '0;
        bus.out_valid <= 1'b0;
        bus.out_data  <= '0;
        if (WARMUP > 0) begin
          fsm      <= ST_WARM;
          warm_cnt <= WARM_WORDS;
          keyed    <= 1'b0;
        end else begin
          fsm      <= ST_RUN;
          warm_cnt <= 8'd0;
          keyed    <= 1'b1;
        end
      end else begin
        case (fsm)
          ST_WARM: begin
            lfsr     <= lfsr_next;
            warm_cnt <= warm_cnt - 8'd1;
            if (warm_cnt <= 8'd1) begin
              fsm   <= ST_RUN;
              keyed <= 1'b1;
            end else begin
              keyed <= 1'b0;
            end
          end
          ST_RUN: begin
            keyed <= 1'b1;
            if (accept) begin
              bus.out_data  <= bus.in_data ^ lfsr[DATA_W-1:0];
              bus.out_valid <= 1'b1;
              lfsr          <= lfsr_next;
              word_count    <= word_count + CNT_W'(1);
            end else if (bus.out_valid && bus.out_ready) begin
              bus.out_valid <= 1'b0;
            end else begin
              bus.out_valid <= bus.out_valid;
            end
          end
          ST_UNKEYED: begin
            keyed <= 1'b0;
          end
          default: begin
            fsm   <= ST_UNKEYED;
            keyed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/stream_cipher_core.md
Name: stream_cipher_core

Overview:
- Parametrised successor to the byte-wide XOR stream cypher: a keyed Galois-LFSR keystream generator XORed onto a DATA_W-wide data stream.
- Valid/ready handshakes on input and output, registered output, key load with optional warm-up, and a word counter.
- Encrypt and decrypt are the same operation: the same key and sequence restore the plaintext.
- Sits between the pad/IO wrapper and the user data path.

Parameters:
- DATA_W, 8, data word width; 1..LFSR_W.
- LFSR_W, 16, keystream state and key width; >= DATA_W.
- TAPS, 16'hB400, Galois feedback mask, LFSR_W bits wide.
- WARMUP, 0, whole words of keystream discarded after each key load (0..255).
- CNT_W, 16, width of the processed-word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable; when 0, all state holds.
- key_load  in  1  single-cycle strobe; loads key_in.
- key_in  in  LFSR_W  key / LFSR seed.
- in_valid  in  1  input word valid.
- in_ready  out  1  core can accept an input word.
- in_data  in  DATA_W  plaintext or ciphertext.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  DATA_W  in_data XOR keystream.
- keyed  out  1  key loaded and warm-up complete.
- word_count  out  CNT_W  words accepted since the last key load.

Behaviour:
- Reset is applied when rst_n=0 at a clk edge, regardless of ena. All outputs are 0, the LFSR state is 0, and the FSM is in UNKEYED.
- LFSR step (one step): the old state's lsb is saved, state = state>>1, then state ^= TAPS if the saved lsb was 1.
- Word advance: DATA_W consecutive steps, performed combinationally within one cycle.
- Keystream word: state[DATA_W-1:0], taken before the advance.
- FSM states:
  - UNKEYED: in_ready=0. key_load loads the key and goes to WARM if WARMUP>0, otherwise to RUN.
  - WARM: performs one word advance per enabled cycle with no data accepted, for WARMUP cycles, then goes to RUN. keyed=0.
  - RUN: keyed=1; processes data.
- Key load:
  - state <= key_in; if key_in==0, state <= 1 instead, so the LFSR never locks up.
  - Clears word_count, out_valid and out_data.
  - Any pending output word is discarded.
  - key_load is honoured in every state and has priority over a same-cycle input accept; that input word is not consumed.
- in_ready = ena & (state==RUN) & ~key_load & (~out_valid | out_ready). Combinational; no dependence on in_valid.
- Accept = in_valid & in_ready. On accept:
  - out_data <= in_data ^ keystream; out_valid <= 1.
  - LFSR performs one word advance; word_count += 1, wrapping from all-ones to 0.
- Latency: one cycle from accept to out_valid. Throughput: one word per cycle under continuous out_ready.
- Output handshake:
  - out_valid & ~out_ready: out_data and out_valid hold stable and in_ready=0.
  - out_valid & out_ready & no accept: out_valid <= 0; out_data holds its last value.
  - Simultaneous drain and accept: the new word replaces the old one with no bubble.
- ena=0: nothing changes except under reset. in_ready=0, and key_load is ignored.
- The LFSR and counter advance only on accept (and during WARM). Stalls never consume keystream.
- rst_n low mid-stream or mid-warm-up returns the core to UNKEYED with all outputs 0 on the next edge.

Test Plan:
1. Reset, then key_load with key_in=16'hACE1, WARMUP=0. Send 8'hAA then 8'h55 with out_ready=1.
   -> keyed=1 the cycle after the load; out_data=8'h4B then 8'h91 (keystream 8'hE1, 8'hC4); word_count=2.
2. Reload 16'hACE1 and send 8'h4B then 8'h91.
   -> out_data=8'hAA then 8'h55 (decrypt round trip); word_count reset to 0 at the load.
3. Backpressure: out_ready=0 for 3 cycles after the first accept.
   -> out_data holds 8'h4B, in_ready=0, no LFSR advance. Then raise out_ready with in_valid held high on 8'h55.
   -> next output is 8'h91, with no bubble and no lost word.
4. key_in=0 and send 8'h00.
   -> out_data=8'h01, because the seed is forced to 1.
5. WARMUP=1, key 16'hACE1, send 8'hAA.
   -> keyed stays 0 for one cycle after the load, then goes to 1; out_data=8'h6E (keystream 8'hC4).
6. Corner cases:
   - key_load in the same cycle as in_valid: the word is not accepted and the output is cleared.
   - ena=0 with in_valid=1: no change.
   - rst_n=0 mid-stream: all outputs are 0 next cycle and keyed=0.
   - word_count wrap with CNT_W=2: 4 accepts return the count to 0.
